dither_expander: RTL and testbench
==================================

Name: dither_expander

Overview:
- Converts a 16-bit high-resolution sample into a stream of 8-bit output words, one per output strobe.
- The mean of each group of 2^power consecutive output words equals the 16-bit input exactly: the upper byte is the integer part, the lower byte is a fraction in units of 1/256.
- Uses first-order error-feedback dithering, i.e. the inverse of the oversampling averager.
- Sits between a 16-bit sample producer and an 8-bit DAC/PWM driver. The output rate is set by the strobe.

Parameters:
- power, default 8: each accepted input word is emitted for 2^power output strobes. Must be >= 8; elaboration error otherwise.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- EN  input  1  output-rate strobe; one output word is produced per cycle with EN=1.
- din_valid  input  1  producer has a word on din.
- din  input  16  sample: din[15:8] is the integer part, din[7:0] the fraction/256.
- din_ready  output  1  one-entry input buffer is empty.
- dout  output  8  dithered output word, registered.
- dout_strobe  output  1  one-cycle pulse, high in the cycle dout has just updated.
- underrun  output  1  one-cycle pulse when a sample period ends with no buffered word.

Behaviour:
- Reset values:
  - dout=0, dout_strobe=0, underrun=0, din_ready=1.
  - Internal: buf_full=0, cur=0, err=0, cnt=0, state=EMPTY.
  - Reset asserted mid-run aborts immediately, with the same values.
- Input handshake:
  - A word is accepted on the edge where din_valid & din_ready.
  - buf <= din and buf_full <= 1 on that edge.
  - din_ready = !buf_full, driven from a register only; no combinational path from EN or din_valid.
- State EMPTY:
  - EN is ignored; dout holds its value; dout_strobe=0.
  - If buf_full: cur <= buf, buf_full <= 0, cnt <= 0, err kept, state -> RUN.
  - The first word is usable one edge after acceptance.
- State RUN, on each EN=1 edge:
  - s = {1'b0,err} + cur[7:0] (9-bit); carry = s[8]; err <= s[7:0].
  - dout <= (cur[15:8]==8'hFF) ? 8'hFF : cur[15:8] + carry. Saturates; never wraps to 0.
  - dout_strobe <= 1; cnt <= cnt + 1 (power-bit counter, wraps).
- End of sample period (EN=1 and cnt == 2^power-1):
  - If buf_full: cur <= buf, buf_full <= 0. The new value applies from the next strobe.
  - Else: cur is kept (sample repeats) and underrun <= 1 for one cycle.
  - In both cases err is not cleared, so the carry sequence stays continuous across samples.
- Exactness: with err continuous, the number of carries over any aligned 2^power-strobe period equals cur[7:0] * 2^(power-8). The mean is exact for all non-saturated inputs.
- Simultaneous acceptance and drain: not possible, because din_ready=0 whenever buf_full=1. A word offered at the drain edge is accepted one cycle later.
- EN=0 cycles: no state change except input acceptance; dout_strobe=0.
- State RUN never returns to EMPTY except via reset.
- Latency: acceptance edge k; cur is loaded at edge k+1 (from EMPTY); the first dout is on the first EN edge after k+1.

Decomposition:
- Package dither_pkg:
  - typedef enum {EMPTY, RUN} dither_state_t.
  - Constants: SAMPLE_W=16, OUT_W=8, FRAC_W=8.
  - Function sat_add8(int8, carry) returning the saturated sum.
- Sub-module frac_accum: holds err and the 9-bit add; inputs frac[7:0] and step; outputs carry. Instantiated once.
- The handshake buffer, counter and FSM live in dither_expander.

Test Plan:
- din=16'h8040 accepted, EN every 4th cycle, power=8 -> over 256 strobes: dout=8'h80 ×192, 8'h81 ×64, sum = 32832; no underrun until strobe 256, then one pulse.
- din=16'hFFFF -> dout=8'hFF on every strobe, never 8'h00.
- Back-to-back words 16'h1000, 16'h2080, 16'h3000 offered continuously:
  - First two accepted.
  - din_ready=0 during strobes 1-256 of word 1; third word accepted one cycle after the drain at strobe 256.
  - Strobes 257-512 average to exactly 32.5.
- Single word 16'h4001, EN continuous for 768 strobes -> underrun pulses at strobes 256, 512, 768; carries total 3; dout in {8'h40, 8'h41}.
- Reset asserted asynchronously at strobe 100 of word 16'h55AA -> dout=0, din_ready=1, state EMPTY in the same cycle; after release, the next word restarts with err=0.
- Loopback: dout/dout_strobe drive averager_simple #(8) EN/Din, with input 16'hA37C held -> averager Q == 16'hA37C after 256 strobes, and on every strobe thereafter.

Source files
------------

// File: rtl/dither_pkg.sv
// Shared types and helpers for the dither expander: FSM states, widths, saturating add.
// Purely combinational definitions; no state or flow control lives here.
package dither_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        RUN   = 1'b1
    } dither_state_t;

    localparam int SAMPLE_W = 16;
    localparam int OUT_W    = 8;
    localparam int FRAC_W   = 8;

    // Integer part plus carry, pinned at full scale so 8'hFF never wraps to 8'h00.
    function automatic logic [OUT_W-1:0] sat_add8(input logic [OUT_W-1:0] int8, input logic carry);
        return (int8 == {OUT_W{1'b1}}) ? int8 : int8 + {{(OUT_W-1){1'b0}}, carry};
    endfunction

endpackage

// File: rtl/dither_expander_if.sv
// Sample-in / dithered-byte-out bundle; master is the producer+rate source, slave the expander.
// Input side is valid/ready; output side is a strobe with no backpressure.
interface dither_expander_if;
    import dither_pkg::*;

    logic                EN;
    logic                din_valid;
    logic [SAMPLE_W-1:0] din;
    logic                din_ready;
    logic [OUT_W-1:0]    dout;
    logic                dout_strobe;
    logic                underrun;

    modport master (
        output EN, din_valid, din,
        input  din_ready, dout, dout_strobe, underrun
    );

    modport slave (
        input  EN, din_valid, din,
        output din_ready, dout, dout_strobe, underrun
    );

endinterface

// File: rtl/frac_accum.sv
// First-order error-feedback accumulator: carry out is combinational, residue updates on step.
// No flow control; the owner decides when to step.
module frac_accum
    import dither_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [FRAC_W-1:0] i_frac,
    input  logic              i_step,
    output logic              o_carry
);

    logic [FRAC_W-1:0] r_err;
    logic [FRAC_W:0]   w_sum;

    assign w_sum   = {1'b0, r_err} + {1'b0, i_frac};
    assign o_carry = w_sum[FRAC_W];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_err <= '0;
        end else if (i_step) begin
            r_err <= w_sum[FRAC_W-1:0];
        end
    end

endmodule

// File: rtl/dither_expander.sv
// Expands each 16-bit sample into 2^power dithered bytes whose mean equals the sample exactly.
// First byte on the first EN edge after the load edge; one-entry buffer, din_ready = buffer empty.
module dither_expander
    import dither_pkg::*;
#(
    parameter int unsigned power = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    dither_expander_if.slave        bus
);

    generate
        if (power < 8) begin : g_bad_power
            $error("dither_expander: power must be >= 8");
        end
    endgenerate

    localparam logic [power-1:0] CNT_ONE = {{(power-1){1'b0}}, 1'b1};

    dither_state_t       r_state, w_state_nxt;
    logic [SAMPLE_W-1:0] r_buf, w_buf_nxt;
    logic                r_buf_full, w_buf_full_nxt;
    logic [SAMPLE_W-1:0] r_cur, w_cur_nxt;
    logic [power-1:0]    r_cnt, w_cnt_nxt;
    logic [OUT_W-1:0]    r_dout, w_dout_nxt;
    logic                r_strobe, w_strobe_nxt;
    logic                r_underrun, w_underrun_nxt;
    logic                w_step;
    logic                w_carry;

    frac_accum u_frac_accum (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_frac  (r_cur[FRAC_W-1:0]),
        .i_step  (w_step),
        .o_carry (w_carry)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= EMPTY;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_cur      <= '0;
            r_cnt      <= '0;
            r_dout     <= '0;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_buf      <= w_buf_nxt;
            r_buf_full <= w_buf_full_nxt;
            r_cur      <= w_cur_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dout     <= w_dout_nxt;
            r_strobe   <= w_strobe_nxt;
            r_underrun <= w_underrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_buf_nxt      = r_buf;
        w_buf_full_nxt = r_buf_full;
        w_cur_nxt      = r_cur;
        w_cnt_nxt      = r_cnt;
        w_dout_nxt     = r_dout;
        w_strobe_nxt   = 1'b0;
        w_underrun_nxt = 1'b0;
        w_step         = 1'b0;

        // Acceptance and drain never coincide: a full buffer already blocks din_ready.
        if (bus.din_valid && !r_buf_full) begin
            w_buf_nxt      = bus.din;
            w_buf_full_nxt = 1'b1;
        end

        case (r_state)
            EMPTY: begin
                if (r_buf_full) begin
                    w_cur_nxt      = r_buf;
                    w_buf_full_nxt = 1'b0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = RUN;
                end
            end
            RUN: begin
                if (bus.EN) begin
                    w_step       = 1'b1;
                    w_dout_nxt   = sat_add8(r_cur[SAMPLE_W-1:FRAC_W], w_carry);
                    w_strobe_nxt = 1'b1;
                    w_cnt_nxt    = r_cnt + CNT_ONE;
                    // Residue is never cleared here so the carry pattern stays continuous.
                    if (&r_cnt) begin
                        if (r_buf_full) begin
                            w_cur_nxt      = r_buf;
                            w_buf_full_nxt = 1'b0;
                        end else begin
                            w_underrun_nxt = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    assign bus.din_ready   = ~r_buf_full;
    assign bus.dout        = r_dout;
    assign bus.dout_strobe = r_strobe;
    assign bus.underrun    = r_underrun;

endmodule

// File: tb/tb_dither_expander.sv
// Directed bench for dither_expander: reset, dithering sums, saturation, back-to-back, underrun, async reset, loopback mean.
module tb_dither_expander;
    import dither_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dither_expander_if bus();

    dither_expander #(.power(8)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int strobe_cnt;
    int dsum;
    int u_at[$];
    logic [7:0] dlog[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        strobe_cnt = 0;
        dsum       = 0;
        u_at.delete();
        dlog.delete();
    endtask

    task automatic step(input logic en);
        bus.EN = en;
        tick();
        if (bus.dout_strobe) begin
            strobe_cnt++;
            dsum += int'(bus.dout);
            dlog.push_back(bus.dout);
        end
        if (bus.underrun) u_at.push_back(strobe_cnt);
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        bus.EN        = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        tick();
        tick();
        rst = 1'b0;
        clear_log();
    endtask

    task automatic push_word(input logic [15:0] w, output bit ok);
        bus.din       = w;
        bus.din_valid = 1'b1;
        ok            = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (bus.din_ready) ok = 1'b1;
            step(bus.EN);
        end
        bus.din_valid = 1'b0;
    endtask

    task automatic run_until(input int n, input int period, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20000 && !ok; c++) begin
            step((c % period) == 0);
            if (strobe_cnt >= n) ok = 1'b1;
        end
        bus.EN = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.EN        = 1'b1;
        bus.din_valid = 1'b1;
        bus.din       = 16'hBEEF;
        tick();
        checks++; if (bus.dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h want=00", bus.dout); end
        checks++; if (bus.dout_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b want=0", bus.dout_strobe); end
        checks++; if (bus.underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b want=0", bus.underrun); end
        checks++; if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus.din_ready); end
        apply_reset();
    endtask

    task automatic test_dither_8040();
        bit ok;
        int n80, n81;
        apply_reset();
        push_word(16'h8040, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL d8040_accept got=%b want=1", ok); end
        step(1'b0);
        checks++; if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL d8040_ready_after_load got=%b want=1", bus.din_ready); end
        run_until(256, 4, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL d8040_timeout got=%b want=1", ok); end
        n80 = 0; n81 = 0;
        for (int i = 0; i < dlog.size(); i++) begin
            if (dlog[i] == 8'h80) n80++;
            if (dlog[i] == 8'h81) n81++;
        end
        checks++; if (n80 !== 192) begin failures++; $display("FAIL d8040_n80 got=%0d want=192", n80); end
        checks++; if (n81 !== 64) begin failures++; $display("FAIL d8040_n81 got=%0d want=64", n81); end
        checks++; if (dsum !== 32832) begin failures++; $display("FAIL d8040_sum got=%0d want=32832", dsum); end
        checks++;
        if (u_at.size() != 1 || u_at[0] != 256) begin
            failures++;
            $display("FAIL d8040_underrun got_count=%0d first=%0d want=1@256", u_at.size(), (u_at.size() > 0) ? u_at[0] : -1);
        end
    endtask

    task automatic test_saturate();
        bit ok;
        int bad;
        apply_reset();
        push_word(16'hFFFF, ok);
        run_until(300, 1, ok);
        checks++; if (dlog.size() !== 300) begin failures++; $display("FAIL sat_strobes got=%0d want=300", dlog.size()); end
        bad = 0;
        for (int i = 0; i < dlog.size(); i++) if (dlog[i] != 8'hFF) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL sat_not_ff got=%0d want=0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        int acc_str [3];
        int idx, busy_err, s1, s2;
        bit acc;
        words[0] = 16'h1000; words[1] = 16'h2080; words[2] = 16'h3000;
        acc_str[0] = -1; acc_str[1] = -1; acc_str[2] = -1;
        apply_reset();
        idx = 0; busy_err = 0;
        bus.din = words[0];
        bus.din_valid = 1'b1;
        for (int c = 0; c < 3000 && strobe_cnt < 512; c++) begin
            acc = bus.din_valid && bus.din_ready;
            if (acc) acc_str[idx] = strobe_cnt;
            step(1'b1);
            if (acc) begin
                idx++;
                if (idx < 3) bus.din = words[idx];
                else bus.din_valid = 1'b0;
            end
            if (bus.dout_strobe && strobe_cnt >= 1 && strobe_cnt <= 255 && bus.din_ready) busy_err++;
        end
        bus.EN = 1'b0;
        bus.din_valid = 1'b0;
        checks++; if (idx !== 3) begin failures++; $display("FAIL b2b_accepted got=%0d want=3", idx); end
        checks++; if (acc_str[1] !== 0) begin failures++; $display("FAIL b2b_w2_at got=%0d want=0", acc_str[1]); end
        checks++; if (acc_str[2] !== 256) begin failures++; $display("FAIL b2b_w3_at got=%0d want=256", acc_str[2]); end
        checks++; if (busy_err !== 0) begin failures++; $display("FAIL b2b_ready_busy got=%0d want=0", busy_err); end
        s1 = 0; s2 = 0;
        for (int i = 0; i < dlog.size(); i++) begin
            if (i < 256) s1 += int'(dlog[i]);
            else if (i < 512) s2 += int'(dlog[i]);
        end
        checks++; if (s1 !== 4096) begin failures++; $display("FAIL b2b_sum1 got=%0d want=4096", s1); end
        checks++; if (s2 !== 8320) begin failures++; $display("FAIL b2b_sum2 got=%0d want=8320", s2); end
    endtask

    task automatic test_underrun();
        bit ok;
        int n41, nother;
        apply_reset();
        push_word(16'h4001, ok);
        run_until(768, 1, ok);
        checks++;
        if (u_at.size() != 3 || u_at[0] != 256 || u_at[1] != 512 || u_at[2] != 768) begin
            failures++;
            $display("FAIL und_pulses got_count=%0d want=3@256,512,768", u_at.size());
        end
        n41 = 0; nother = 0;
        for (int i = 0; i < dlog.size(); i++) begin
            if (dlog[i] == 8'h41) n41++;
            else if (dlog[i] != 8'h40) nother++;
        end
        checks++; if (n41 !== 3) begin failures++; $display("FAIL und_carries got=%0d want=3", n41); end
        checks++; if (nother !== 0) begin failures++; $display("FAIL und_range got=%0d want=0", nother); end
    endtask

    task automatic test_async_reset();
        bit ok;
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'h10; exp_seq[1] = 8'h11; exp_seq[2] = 8'h11; exp_seq[3] = 8'h11;
        apply_reset();
        push_word(16'h55AA, ok);
        run_until(100, 1, ok);
        push_word(16'h1234, ok);
        checks++; if (bus.din_ready !== 1'b0) begin failures++; $display("FAIL ar_pre_ready got=%b want=0", bus.din_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.dout !== 8'h00) begin failures++; $display("FAIL ar_dout got=%h want=00", bus.dout); end
        checks++; if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL ar_ready got=%b want=1", bus.din_ready); end
        checks++; if (dut.r_state !== EMPTY) begin failures++; $display("FAIL ar_state got=%0d want=EMPTY", dut.r_state); end
        #1 rst = 1'b0;
        tick();
        clear_log();
        push_word(16'h10C0, ok);
        run_until(4, 1, ok);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dlog.size() <= i || dlog[i] !== exp_seq[i]) begin
                failures++;
                $display("FAIL ar_restart_%0d got=%h want=%h", i, (dlog.size() > i) ? dlog[i] : 8'hxx, exp_seq[i]);
            end
        end
    endtask

    task automatic test_loopback();
        bit ok;
        int win[$];
        int wsum, seen, bad;
        apply_reset();
        push_word(16'hA37C, ok);
        wsum = 0; seen = 0; bad = 0;
        for (int c = 0; c < 2000 && strobe_cnt < 400; c++) begin
            step(1'b1);
            if (strobe_cnt > seen) begin
                seen = strobe_cnt;
                win.push_back(int'(dlog[dlog.size()-1]));
                wsum += win[win.size()-1];
                if (win.size() > 256) wsum -= win.pop_front();
                if (strobe_cnt >= 256) begin
                    checks++;
                    if (wsum[15:0] !== 16'hA37C) begin
                        failures++;
                        $display("FAIL loop_mean strobe=%0d got=%h want=a37c", strobe_cnt, wsum[15:0]);
                    end
                end
            end
        end
        bus.EN = 1'b0;
        checks++; if (seen !== 400) begin failures++; $display("FAIL loop_strobes got=%0d want=400", seen); end
    endtask

    initial begin
        rst           = 1'b1;
        bus.EN        = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        clear_log();
        test_reset();
        test_dither_8040();
        test_saturate();
        test_back_to_back();
        test_underrun();
        test_async_reset();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
